// File: rtl/alu_seq_ctrl_if.sv
// Byte-stream, ALU-load and result handshake signals of the ALU sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface alu_seq_ctrl_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_sw;
  logic         alu_en_a;
  logic         alu_en_b;
  logic         alu_en_op;
  logic [W-1:0] alu_y;
  logic [4:0]   alu_flags;
  logic [W-1:0] out_data;
  logic [4:0]   out_flags;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport slave (
    input  in_data, in_valid, alu_y, alu_flags, out_ready,
    output in_ready, alu_sw, alu_en_a, alu_en_b, alu_en_op,
           out_data, out_flags, out_valid, busy
  );

  modport master (
    output in_data, in_valid, alu_y, alu_flags, out_ready,
    input  in_ready, alu_sw, alu_en_a, alu_en_b, alu_en_op,
           out_data, out_flags, out_valid, busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Loads A, B and opcode bytes into the ALU top, waits SETTLE cycles and returns the result.
// Optional ALU_SEQ_FLAGS_BYTE_EN: a second result byte carrying the flags follows y.
module alu_seq_ctrl #(
  parameter int W      = 8,
  parameter int WOP    = 6,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           rst,
  alu_seq_ctrl_if.slave bus
);

  if (SETTLE < 1 || SETTLE > 15 || WOP > W || W < 5) begin : g_param_check
    $error("alu_seq_ctrl: illegal parameter set");
  end

`ifdef ALU_SEQ_FLAGS_BYTE_EN
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_WAIT, S_RES, S_FLG} state_t;
`else
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_WAIT, S_RES} state_t;
`endif

  state_t       state;
  logic [3:0]   settle_cnt;
  logic [W-1:0] out_data_r;
  logic [4:0]   out_flags_r;
  logic         out_valid_r;
  logic         in_ready_c;
  logic         in_hs;

  assign in_ready_c = (state == S_A) || (state == S_B) || (state == S_OP);
  assign in_hs      = bus.in_valid && in_ready_c && !rst;

  // Enables are combinational so the ALU registers load on the handshake edge itself.
  assign bus.in_ready  = in_ready_c;
  assign bus.alu_sw    = bus.in_data;
  assign bus.alu_en_a  = in_hs && (state == S_A);
  assign bus.alu_en_b  = in_hs && (state == S_B);
  assign bus.alu_en_op = in_hs && (state == S_OP);
  assign bus.busy      = (state != S_A);
  assign bus.out_data  = out_data_r;
  assign bus.out_flags = out_flags_r;
  assign bus.out_valid = out_valid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_A;
      settle_cnt  <= 4'd0;
      out_data_r  <= '0;
      out_flags_r <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_A: if (in_hs) state <= S_B;
        S_B: if (in_hs) state <= S_OP;
        S_OP: begin
          if (in_hs) begin
            state      <= S_WAIT;
            settle_cnt <= 4'(SETTLE - 1);
          end
        end
        S_WAIT: begin
          if (settle_cnt == 4'd0) begin
            out_data_r  <= bus.alu_y;
            out_flags_r <= bus.alu_flags;
            out_valid_r <= 1'b1;
            state       <= S_RES;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_RES: begin
          if (out_valid_r && bus.out_ready) begin
`ifdef ALU_SEQ_FLAGS_BYTE_EN
            // Result byte taken; keep valid high and present the flags byte next.
            out_data_r <= {{(W-5){1'b0}}, out_flags_r};
            state      <= S_FLG;
`else
            out_valid_r <= 1'b0;
            state       <= S_A;
`endif
          end
        end
`ifdef ALU_SEQ_FLAGS_BYTE_EN
        S_FLG: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_A;
          end
        end
`endif
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer that feeds the 8-bit ALU top block from a byte stream, for example a UART RX path.
- Consumes three bytes in order (operand A, operand B, opcode). Drives the load enables and the shared switch bus of the ALU top, waits for the result to settle, then returns the result through a valid/ready output port.
- Sits between the serial front-end and the ALU top, in place of the manual switch/button loading.

Parameters:
- W, 8, data width of operands, result and input byte.
- WOP, 6, opcode width; only in_data[WOP-1:0] is meaningful for the opcode byte.
- SETTLE, 1, cycles waited after the opcode load before capturing the result; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- in_data  input  W  incoming byte
- in_valid  input  1  in_data valid
- in_ready  output  1  controller accepts a byte this cycle
- alu_sw  output  W  shared load bus to the ALU top
- alu_en_a  output  1  load operand A register
- alu_en_b  output  1  load operand B register
- alu_en_op  output  1  load opcode register
- alu_y  input  W  ALU result
- alu_flags  input  5  {carry, borrow, overflow, zero, neg} from the ALU
- out_data  output  W  result byte
- out_flags  output  5  flags captured with the result
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- busy  output  1  high in any state other than S_A

Behaviour:
- States: S_A, S_B, S_OP, S_WAIT, S_RES.
- Reset (synchronous, any state, including mid-sequence):
  - state=S_A, out_valid=0, out_data=0, out_flags=0, settle counter=0.
  - The ALU input registers share rst and clear in the same edge.
- in_ready=1 only in S_A, S_B, S_OP. It is 0 in S_WAIT and S_RES.
- Handshake is in_valid & in_ready at the rising edge.
- alu_sw = in_data, combinational pass-through in every state.
- Load enables are combinational, so the ALU registers load in the same edge as the handshake:
  - alu_en_a = in_valid & in_ready & (state==S_A).
  - alu_en_b and alu_en_op are the same, gated by S_B and S_OP.
  - At most one enable is high in any cycle. All enables are 0 in S_WAIT, S_RES and during rst.
- S_A: on handshake, go to S_B. In S_B and S_OP the bytes load the B and opcode registers and advance the same way.
- S_OP: on handshake, go to S_WAIT and load counter=SETTLE-1.
- S_WAIT:
  - If the counter is 0, capture out_data<=alu_y and out_flags<=alu_flags, set out_valid=1, and go to S_RES.
  - Otherwise decrement the counter.
  - With SETTLE=1 the capture happens on the first edge after the opcode load.
- Latency: opcode-byte handshake edge to out_valid high is SETTLE cycles.
- S_RES:
  - out_data and out_flags are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_valid & out_ready: out_valid=0 and go to S_A.
  - A new byte is accepted no earlier than the cycle after the result handshake, so there is no input/output overlap.
- in_valid high while in_ready=0: ignored; no enable is asserted and no state change occurs.
- Upper in_data bits above WOP on the opcode byte are ignored; the ALU top uses only the low WOP bits.
- No timeout: a partially entered sequence waits indefinitely. Only rst aborts it.
- The ALU registers retain A/B/OP after completion. Each new sequence reloads all three.

Optional Feature:
- Macro ALU_SEQ_FLAGS_BYTE_EN.
- Defined:
  - After the result byte handshake, the controller moves to S_FLG instead of S_A.
  - In S_FLG: out_data={(W-5)'b0, out_flags}, out_valid=1. Hold until out_ready, then go to S_A.
  - The result stream becomes 2 bytes: y, then flags.
- Undefined:
  - S_FLG does not exist; only the single result byte is sent.
  - out_flags is still presented in parallel with it.

Test Plan:
- Reset, then stream A=0x05, B=0x03, OP=0x20 (ADD) with out_ready=1 -> alu_en_a/b/op pulse for exactly one cycle each on their handshakes; out_data=0x08, zero=0, out_valid for 1 cycle SETTLE cycles after the OP byte; busy back to 0.
- A=0x03, B=0x05, OP=0x22 (SUB) with out_ready=0 for 10 cycles -> out_data=0xFE, neg=1, borrow=1, all held stable for 10 cycles; in_ready=0 throughout; a byte offered with in_valid meanwhile is not consumed and no enable pulses.
- A=0x0F, B=0xF0, OP=0x24 (AND) -> out_data=0x00, zero=1.
- Send A=0x11 and B=0x22, assert rst for 1 cycle, then send 0x01, 0x01, 0x20 -> first two bytes are discarded, out_data=0x02, state restarted at S_A.
- Gapped in_valid (1 cycle valid, 3 idle, repeated) with SETTLE=4 -> the same results as back-to-back input; out_valid rises exactly 4 cycles after the OP handshake.
- With ALU_SEQ_FLAGS_BYTE_EN defined, SUB case -> two output bytes 0xFE then a flags byte with neg and borrow bits set ({000, carry, borrow, overflow, zero, neg}); in_ready stays 0 until the second byte is accepted.
